alu0_writeback: RTL and testbench
=================================

Name: alu0_writeback

Overview:
Write-back stage for the ALU0 pipe. It sits after the ALU0 execute stage, which is itself fed by the ALU0 register-read stage.
- Captures each executed result into a one-entry WB register.
- Writes that result into the 64x32 physical regfile.
- Broadcasts it as the ALU0 bypass pair (PR, data), which the ALU0 register-read stage consumes.
- Raises a wakeup for the issue queues.
- Reports completion to the ROB through a small valid/ready completion queue that absorbs ROB back-pressure.

Parameters:
- PR_W, 6, physical register index width (64 PRs).
- ROB_W, 6, ROB ID width.
- DATA_W, 32, datapath width.
- CQ_DEPTH, 2, completion queue entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush (branch mispredict / exception).
- ex_vld  in  1  execute result valid.
- ex_ready  out  1  WB can accept a result this cycle.
- ex_dest  in  PR_W  destination PR.
- ex_ROB_ID  in  ROB_W  ROB entry of the instruction.
- ex_result  in  DATA_W  ALU result.
- rf_we  out  1  regfile write enable.
- rf_waddr  out  PR_W  regfile write PR.
- rf_wdata  out  DATA_W  regfile write data.
- ALU0_PR_bypass  out  PR_W  bypass PR tag; 0 when nothing is forwarded.
- ALU0_data_bypass  out  DATA_W  bypass data; 0 when nothing is forwarded.
- wake_vld  out  1  wakeup strobe.
- wake_PR  out  PR_W  PR made ready.
- rob_cmp_vld  out  1  completion valid.
- rob_cmp_ROB_ID  out  ROB_W  completing ROB entry.
- rob_cmp_ready  in  1  ROB accepts the completion.

Behaviour:
- Reset (async, rst_n low):
  - WB valid=0, queue empty, count=0.
  - All outputs 0 except ex_ready=1.
  - Asserting rst_n mid-operation discards the WB entry and all queued completions with no partial output.
- Accept condition: acc = ex_vld & ex_ready & ~flush.
- Edge after acc (cycle T):
  - WB register loads {dest, result}; WB valid=1.
  - ex_ROB_ID is pushed into the completion queue.
  - If acc=0, WB valid=0 on that edge.
- WB outputs in cycle T+1, combinational from the WB register:
  - rf_we = wbv & (dest!=0); rf_waddr = dest; rf_wdata = result. The write commits at the end of T+1.
  - ALU0_PR_bypass = wbv ? dest : 0; ALU0_data_bypass = wbv ? result : 0.
  - wake_vld = wbv & (dest!=0); wake_PR = dest.
  - Bypass must be valid in T+1 because the regfile value is only visible from T+2.
- PR 0 is hardwired zero: dest=0 produces no write and no wakeup, and the bypass reads 0/0. A completion is still pushed.
- Completion queue:
  - FIFO with CQ_DEPTH entries and wrap-around rd/wr pointers.
  - rob_cmp_vld = (count!=0); rob_cmp_ROB_ID = head entry.
  - Pop when rob_cmp_vld & rob_cmp_ready.
  - Latency: acc at T gives rob_cmp_vld at T+1 if the queue was empty. No combinational path from ex_* to rob_cmp_*.
- ex_ready = (count < CQ_DEPTH), registered-state only. It does not depend on rob_cmp_ready in the same cycle, so when full, a pop does not enable a same-cycle push.
- Count rules:
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - Push only: +1. Pop only: -1. Count never exceeds CQ_DEPTH and never underflows.
- Flush (synchronous, takes priority over everything):
  - On the flush edge: WB valid->0, queue cleared (count=0, pointers=0), and the ex_vld offered in the flush cycle is dropped.
  - In the flush cycle itself, combinational outputs still reflect the pre-flush WB entry. That regfile write completes, because a PR write by an older instruction is harmless.
  - rob_cmp_vld may still be high in the flush cycle; the ROB ignores it.
- Back-to-back results are accepted every cycle while ex_ready=1, and the WB register is overwritten every cycle.

Decomposition:
- Package wb_pkg: PR_W, ROB_W, DATA_W, PR_ZERO=0, and a typedef wb_entry_t {dest, result}.
- One sub-module, wb_cmp_fifo: a generic valid/ready FIFO with push, pop, count, flush and full outputs. alu0_writeback holds the WB register and the output logic.

Test Plan:
- Single op: ex_vld with dest=5, ROB=3, result=0xDEADBEEF at T -> T+1 shows rf_we=1/waddr=5/wdata=0xDEADBEEF, bypass=(5, 0xDEADBEEF), wake_vld=1/wake_PR=5, rob_cmp_vld=1/ID=3; with rob_cmp_ready=1, T+2 shows all outputs 0.
- Dest zero: dest=0, result=0x1234 -> rf_we=0, wake_vld=0, bypass=(0, 0), rob_cmp ID still delivered.
- Back-pressure: rob_cmp_ready=0, three consecutive ex_vld with ROB IDs 1, 2, 3 -> IDs 1 and 2 accepted; ex_ready=0 in the 3rd cycle, so 3 is held upstream. Raising ready then pops 1, 2, 3 in order, and ex_ready returns to 1 one cycle after the first pop.
- Simultaneous push/pop with a queue of 1 and ready=1 every cycle -> count stays 1, IDs stream in order across pointer wrap (8+ ops).
- Flush: queue holds 2 entries and WB is valid; assert flush together with ex_vld (ROB=9) -> next cycle rob_cmp_vld=0, wake_vld=0, bypass=(0, 0), ex_ready=1, and ROB 9 never appears.
- Reset mid-stream: drop rst_n while the queue is full -> outputs go to 0 immediately (async), ex_ready=1; after release, a fresh op completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the write-back entry type for the ALU0 write-back stage.
package wb_pkg;
    localparam int PR_W     = 6;
    localparam int ROB_W    = 6;
    localparam int DATA_W   = 32;
    localparam int CQ_DEPTH = 2;

    localparam logic [PR_W-1:0] PR_ZERO = 6'd0;

    typedef struct packed {
        logic [PR_W-1:0]   dest;
        logic [DATA_W-1:0] result;
    } wb_entry_t;
endpackage

// File: rtl/wb_cmp_fifo.sv
// Small valid/ready FIFO with wrap-around pointers and a synchronous flush.
module wb_cmp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 6,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full
);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_s, pop_s;

    // Guard push/pop against overflow/underflow, then advance pointers and count.
    always_comb begin
        push_s   = push & (count_q != CNT_FULL);
        pop_s    = pop & (count_q != CNT_ZERO);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Head reads zero when empty so a stale ID never leaks out.
    assign dout  = (count_q != CNT_ZERO) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;
    assign full  = (count_q == CNT_FULL);
endmodule

// File: rtl/alu0_writeback.sv
// ALU0 write-back: one-entry WB register driving regfile write, bypass and wakeup,
// plus a completion queue towards the ROB.
module alu0_writeback
    import wb_pkg::*;
#(
    parameter int CQ_DEPTH = wb_pkg::CQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_vld,
    output logic              ex_ready,
    input  logic [PR_W-1:0]   ex_dest,
    input  logic [ROB_W-1:0]  ex_ROB_ID,
    input  logic [DATA_W-1:0] ex_result,
    output logic              rf_we,
    output logic [PR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [PR_W-1:0]   ALU0_PR_bypass,
    output logic [DATA_W-1:0] ALU0_data_bypass,
    output logic              wake_vld,
    output logic [PR_W-1:0]   wake_PR,
    output logic              rob_cmp_vld,
    output logic [ROB_W-1:0]  rob_cmp_ROB_ID,
    input  logic              rob_cmp_ready
);
    localparam int CW = ((CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1) + 1;

    wb_entry_t      wb_q, wb_d;
    logic           wbv_q, wbv_d;
    logic           acc_s;
    logic           pop_s;
    logic           cq_full_s;
    logic [CW-1:0]  cq_count_s;
    logic           dest_live_s;

    assign acc_s = ex_vld & ex_ready & ~flush;
    assign pop_s = rob_cmp_vld & rob_cmp_ready;

    // The entry is cleared whenever nothing is accepted so every WB output idles at zero.
    always_comb begin
        if (acc_s) begin
            wbv_d = 1'b1;
            wb_d  = '{dest: ex_dest, result: ex_result};
        end else begin
            wbv_d = 1'b0;
            wb_d  = '0;
        end
    end

    // WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbv_q <= 1'b0;
            wb_q  <= '0;
        end else begin
            wbv_q <= wbv_d;
            wb_q  <= wb_d;
        end
    end

    wb_cmp_fifo #(
        .DEPTH (CQ_DEPTH),
        .W     (ROB_W)
    ) u_cmp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (acc_s),
        .din   (ex_ROB_ID),
        .pop   (pop_s),
        .dout  (rob_cmp_ROB_ID),
        .count (cq_count_s),
        .full  (cq_full_s)
    );

    // PR 0 is hardwired zero: never written, never woken, never forwarded.
    assign dest_live_s      = wbv_q & (wb_q.dest != PR_ZERO);
    assign rf_we            = dest_live_s;
    assign rf_waddr         = wb_q.dest;
    assign rf_wdata         = wb_q.result;
    assign ALU0_PR_bypass   = wbv_q ? wb_q.dest : PR_ZERO;
    assign ALU0_data_bypass = (wbv_q && (wb_q.dest != PR_ZERO)) ? wb_q.result : 32'd0;
    assign wake_vld         = dest_live_s;
    assign wake_PR          = wb_q.dest;

    assign rob_cmp_vld = (cq_count_s != CW'(0));
    assign ex_ready    = ~cq_full_s;
endmodule

// File: tb/tb_alu0_writeback.sv
// Randomized and directed bench for alu0_writeback against a queue-based reference model.
module tb_alu0_writeback;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ex_vld = 1'b0;
    logic        ex_ready;
    logic [5:0]  ex_dest = 6'd0;
    logic [5:0]  ex_ROB_ID = 6'd0;
    logic [31:0] ex_result = 32'd0;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [5:0]  ALU0_PR_bypass;
    logic [31:0] ALU0_data_bypass;
    logic        wake_vld;
    logic [5:0]  wake_PR;
    logic        rob_cmp_vld;
    logic [5:0]  rob_cmp_ROB_ID;
    logic        rob_cmp_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: the result last accepted (if any) and the pending ROB IDs in order.
    bit          m_wbv = 1'b0;
    logic [5:0]  m_dest = 6'd0;
    logic [31:0] m_res = 32'd0;
    logic [5:0]  m_q[$];

    always #5 clk = ~clk;

    alu0_writeback dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .ex_vld           (ex_vld),
        .ex_ready         (ex_ready),
        .ex_dest          (ex_dest),
        .ex_ROB_ID        (ex_ROB_ID),
        .ex_result        (ex_result),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .ALU0_PR_bypass   (ALU0_PR_bypass),
        .ALU0_data_bypass (ALU0_data_bypass),
        .wake_vld         (wake_vld),
        .wake_PR          (wake_PR),
        .rob_cmp_vld      (rob_cmp_vld),
        .rob_cmp_ROB_ID   (rob_cmp_ROB_ID),
        .rob_cmp_ready    (rob_cmp_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Compare every output against what the model says the pipe should show right now.
    task automatic check_outputs();
        bit live;
        live = m_wbv && (m_dest != 6'd0);
        check_eq("ex_ready",    {31'd0, ex_ready},    {31'd0, m_q.size() < DEPTH});
        check_eq("rf_we",       {31'd0, rf_we},       {31'd0, live});
        check_eq("rf_waddr",    {26'd0, rf_waddr},    {26'd0, m_wbv ? m_dest : 6'd0});
        check_eq("rf_wdata",    rf_wdata,             m_wbv ? m_res : 32'd0);
        check_eq("bypass_pr",   {26'd0, ALU0_PR_bypass}, {26'd0, m_wbv ? m_dest : 6'd0});
        check_eq("bypass_data", ALU0_data_bypass,     live ? m_res : 32'd0);
        check_eq("wake_vld",    {31'd0, wake_vld},    {31'd0, live});
        check_eq("wake_pr",     {26'd0, wake_PR},     {26'd0, m_wbv ? m_dest : 6'd0});
        check_eq("cmp_vld",     {31'd0, rob_cmp_vld}, {31'd0, m_q.size() != 0});
        check_eq("cmp_id",      {26'd0, rob_cmp_ROB_ID}, {26'd0, (m_q.size() != 0) ? m_q[0] : 6'd0});
    endtask

    // One cycle: check at the falling edge, drive inputs, then advance the model at the rising edge.
    task automatic step(input bit vld, input logic [5:0] dest, input logic [5:0] rob,
                        input logic [31:0] res, input bit fl, input bit rdy);
        bit acc;
        bit pop;
        @(negedge clk);
        check_outputs();
        ex_vld = vld; ex_dest = dest; ex_ROB_ID = rob; ex_result = res;
        flush = fl; rob_cmp_ready = rdy;
        acc = vld && (m_q.size() < DEPTH) && !fl;
        pop = (m_q.size() != 0) && rdy;
        @(posedge clk);
        if (fl) begin
            m_q.delete();
            m_wbv = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(rob);
            m_wbv = acc;
            m_dest = dest;
            m_res = res;
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 6'd0, 6'd0, 32'd0, 1'b0, rdy);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check_outputs();
        @(negedge clk) rst_n = 1'b1;

        // Single op, then drain.
        step(1'b1, 6'd5, 6'd3, 32'hDEADBEEF, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Destination PR 0 still completes.
        step(1'b1, 6'd0, 6'd7, 32'h00001234, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: third op is refused while the queue is full.
        step(1'b1, 6'd10, 6'd1, 32'h11111111, 1'b0, 1'b0);
        step(1'b1, 6'd11, 6'd2, 32'h22222222, 1'b0, 1'b0);
        step(1'b1, 6'd12, 6'd3, 32'h33333333, 1'b0, 1'b0);
        step(1'b1, 6'd12, 6'd3, 32'h33333333, 1'b0, 1'b1);
        step(1'b1, 6'd12, 6'd3, 32'h33333333, 1'b0, 1'b1);
        repeat (3) idle(1'b1);

        // Streaming with simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 6'(i + 1), 6'(20 + i), $urandom, 1'b0, 1'b1);
        end
        repeat (2) idle(1'b1);

        // Flush with a full queue and a valid WB entry; ROB 9 must vanish.
        step(1'b1, 6'd4, 6'd30, 32'hAAAA0000, 1'b0, 1'b0);
        step(1'b1, 6'd6, 6'd31, 32'hBBBB0000, 1'b0, 1'b0);
        step(1'b1, 6'd8, 6'd9,  32'hCCCC0000, 1'b1, 1'b0);
        repeat (2) idle(1'b1);

        // Randomized phases with varying back-pressure and occasional flush.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 250; i++) begin
                logic [5:0] d;
                d = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
                step(($urandom_range(0, 3) != 0), d, 6'($urandom), $urandom,
                     (p == 3) && ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 3) >= p));
            end
        end

        // Asynchronous reset while the queue is full.
        step(1'b1, 6'd13, 6'd40, 32'h0BADF00D, 1'b0, 1'b0);
        step(1'b1, 6'd14, 6'd41, 32'h0BADF00E, 1'b0, 1'b0);
        step(1'b1, 6'd15, 6'd42, 32'h0BADF00F, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        m_q.delete();
        m_wbv = 1'b0;
        check_outputs();
        @(negedge clk);
        ex_vld = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 6'd21, 6'd17, 32'hFEEDFACE, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
